// File: rtl/xgmii_pkg.sv
// xgmii_pkg: XGMII control codes, fixed words and the tx framer state type.
// Shared by tx_xgmii_framer and xgmii_term_insert; no ports.
package xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERR   = 8'hFE;

    localparam logic [63:0] XGMII_PREAMBLE = {56'hD5555555555555, XGMII_START};
    localparam logic [63:0] IDLE_WORD      = {8{XGMII_IDLE}};
    localparam logic [63:0] TERM_WORD      = {{7{XGMII_IDLE}}, XGMII_TERM};
    localparam logic [63:0] ERR_WORD       = {XGMII_TERM, {7{XGMII_ERR}}};

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        TERM,
        IFG,
        DRAIN
    } tx_state_t;

    // Number of consecutive set bits starting at bit 0 (0..8).
    function automatic logic [3:0] lead_ones(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (!keep[i]) n = 4'(i);
        end
        return n;
    endfunction

endpackage

// File: rtl/xgmii_term_insert.sv
// xgmii_term_insert: places /T/ after the valid bytes of a last beat.
// Ports: data/keep in; txd/txc out (lanes < n data, lane n FD, rest 07).
module xgmii_term_insert
    import xgmii_pkg::*;
(
    input  logic [63:0] data,
    input  logic [7:0]  keep,
    output logic [63:0] txd,
    output logic [7:0]  txc
);

    logic [3:0] n;

    // Only the leading run of ones counts; bytes above the first gap are dropped.
    always_comb begin
        n   = lead_ones(keep);
        txd = IDLE_WORD;
        txc = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(n)) begin
                txd[8*i +: 8] = data[8*i +: 8];
                txc[i]        = 1'b0;
            end else if (i == int'(n)) begin
                txd[8*i +: 8] = XGMII_TERM;
            end
        end
    end

endmodule

// File: rtl/tx_xgmii_framer.sv
// tx_xgmii_framer: client beats -> XGMII words with start, /T/, /E/ and IFG.
// Ports: txclk_in, reset_in, tx_data/keep/valid/last/ready, xgmii_txd/txc, pulses.
module tx_xgmii_framer
    import xgmii_pkg::*;
#(
    parameter int IFG_WORDS = 2
)
(
    input  logic        txclk_in,
    input  logic        reset_in,
    input  logic [63:0] tx_data,
    input  logic [7:0]  tx_keep,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic        tx_underrun,
    output logic        tx_frame_done
);

    localparam int CW = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;
    // With no IFG words the framer returns straight to IDLE after /T/.
    localparam tx_state_t POST_T = (IFG_WORDS == 0) ? IDLE : IFG;

    tx_state_t     state;
    logic [CW-1:0] ifg_cnt;
    logic [63:0]   t_txd;
    logic [7:0]    t_txc;
    logic          ifg_end;

    xgmii_term_insert u_term (
        .data (tx_data),
        .keep (tx_keep),
        .txd  (t_txd),
        .txc  (t_txc)
    );

    assign tx_ready = (state == DATA) || (state == DRAIN);
    assign ifg_end  = (int'(ifg_cnt) >= IFG_WORDS - 1);

    always_ff @(posedge txclk_in) begin
        if (reset_in) begin
            state         <= IDLE;
            ifg_cnt       <= '0;
            xgmii_txd     <= IDLE_WORD;
            xgmii_txc     <= 8'hFF;
            tx_underrun   <= 1'b0;
            tx_frame_done <= 1'b0;
        end else begin
            xgmii_txd     <= IDLE_WORD;
            xgmii_txc     <= 8'hFF;
            tx_underrun   <= 1'b0;
            tx_frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tx_valid) begin
                        xgmii_txd <= XGMII_PREAMBLE;
                        xgmii_txc <= 8'h01;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (!tx_valid) begin
                        xgmii_txd   <= ERR_WORD;
                        tx_underrun <= 1'b1;
                        state       <= DRAIN;
                    end else if (!tx_last) begin
                        xgmii_txd <= tx_data;
                        xgmii_txc <= 8'h00;
                    end else begin
                        // A full last beat has no room for /T/; it goes out next word.
                        xgmii_txd <= t_txd;
                        xgmii_txc <= t_txc;
                        if (&tx_keep) begin
                            state <= TERM;
                        end else begin
                            tx_frame_done <= 1'b1;
                            state         <= POST_T;
                        end
                    end
                end
                TERM: begin
                    xgmii_txd     <= TERM_WORD;
                    tx_frame_done <= 1'b1;
                    state         <= POST_T;
                end
                IFG: begin
                    if (ifg_end) begin
                        ifg_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (tx_valid && tx_last) state <= POST_T;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_xgmii_framer.sv
// tb_tx_xgmii_framer: table, directed and randomized checks of the framer.
// Random frames are checked against a byte-level expected word stream.
module tb_tx_xgmii_framer;
    import xgmii_pkg::*;

    localparam int IFG = 2;

    logic        clk = 1'b0;
    logic        reset_in;
    logic [63:0] tx_data;
    logic [7:0]  tx_keep;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        tx_underrun;
    logic        tx_frame_done;

    logic [63:0] u_data;
    logic [7:0]  u_keep;
    logic [63:0] u_txd;
    logic [7:0]  u_txc;

    int checks   = 0;
    int failures = 0;
    bit fired    = 1'b0;
    bit rdy_s    = 1'b0;
    bit seen_t   = 1'b0;
    int idle_run = 0;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        logic        t;
    } xw_t;

    typedef struct {
        logic [7:0]  keep;
        logic [63:0] txd;
        logic [7:0]  txc;
    } tv_t;

    xw_t exp_q[$];
    tv_t tv[12];

    localparam logic [63:0] D0 = 64'h0011223344556677;
    localparam logic [63:0] D1 = 64'h8899AABBCCDDEEFF;
    localparam logic [63:0] D2 = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] ERRW = 64'hFDFEFEFEFEFEFEFE;
    localparam logic [63:0] TW = 64'h07070707070707FD;
    localparam logic [63:0] IW = 64'h0707070707070707;

    always #5 clk = ~clk;

    tx_xgmii_framer #(.IFG_WORDS(IFG)) dut (
        .txclk_in      (clk),
        .reset_in      (reset_in),
        .tx_data       (tx_data),
        .tx_keep       (tx_keep),
        .tx_valid      (tx_valid),
        .tx_last       (tx_last),
        .tx_ready      (tx_ready),
        .xgmii_txd     (xgmii_txd),
        .xgmii_txc     (xgmii_txc),
        .tx_underrun   (tx_underrun),
        .tx_frame_done (tx_frame_done)
    );

    xgmii_term_insert u_ti (
        .data (u_data),
        .keep (u_keep),
        .txd  (u_txd),
        .txc  (u_txc)
    );

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void chkw(string nm, logic [63:0] d, logic [7:0] c,
                                 logic dn, logic un);
        checks++;
        if (xgmii_txd !== d || xgmii_txc !== c ||
            tx_frame_done !== dn || tx_underrun !== un) begin
            failures++;
            $display("FAIL %s: got txd=%h txc=%h done=%b und=%b expected txd=%h txc=%h done=%b und=%b",
                     nm, xgmii_txd, xgmii_txc, tx_frame_done, tx_underrun, d, c, dn, un);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        fired = tx_valid && rdy_s;
        rdy_s = tx_ready;
    endtask

    task automatic expw(string nm, logic [63:0] d, logic [7:0] c,
                        logic dn, logic un);
        step();
        chkw(nm, d, c, dn, un);
    endtask

    function automatic void push_exp(logic [63:0] d, logic [7:0] c, logic t);
        xw_t e;
        e.d = d;
        e.c = c;
        e.t = t;
        exp_q.push_back(e);
    endfunction

    function automatic void monitor();
        xw_t e;
        if (xgmii_txd == IW && xgmii_txc == 8'hFF &&
            !tx_frame_done && !tx_underrun) begin
            idle_run++;
            return;
        end
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rnd_extra_word: got txd=%h txc=%h expected no word",
                     xgmii_txd, xgmii_txc);
            return;
        end
        e = exp_q.pop_front();
        if (e.c == 8'h01 && e.d == XGMII_PREAMBLE && seen_t)
            chk("rnd_ifg_gap", int'(idle_run >= IFG), 1);
        chkw("rnd_word", e.d, e.c, e.t, 1'b0);
        if (e.t) begin
            seen_t   = 1'b1;
            idle_run = 0;
        end
    endfunction

    task automatic rstep();
        step();
        monitor();
    endtask

    task automatic run_random(int nf);
        for (int f = 0; f < nf; f++) begin
            int          len;
            int          r;
            int          nb;
            int          gap;
            int          guard;
            logic [7:0]  by[$];
            logic [63:0] w;
            logic [7:0]  c;
            len = int'($urandom_range(1, 40));
            r   = len % 8;
            nb  = (len + 7) / 8;
            by.delete();
            for (int i = 0; i < len; i++) by.push_back(8'($urandom));
            push_exp(XGMII_PREAMBLE, 8'h01, 1'b0);
            for (int k = 0; k < len / 8; k++) begin
                for (int i = 0; i < 8; i++) w[8*i +: 8] = by[8*k + i];
                push_exp(w, 8'h00, 1'b0);
            end
            if (r == 0) begin
                push_exp(TW, 8'hFF, 1'b1);
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (i < r) w[8*i +: 8] = by[8*(len/8) + i];
                    else if (i == r) w[8*i +: 8] = 8'hFD;
                    else w[8*i +: 8] = 8'h07;
                end
                c = 8'hFF << r;
                push_exp(w, c, 1'b1);
            end
            tx_valid = 1'b0;
            gap = int'($urandom_range(0, 3));
            repeat (gap) rstep();
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < 8; i++) begin
                    if (8*b + i < len) w[8*i +: 8] = by[8*b + i];
                    else w[8*i +: 8] = 8'($urandom);
                end
                tx_data  = w;
                tx_valid = 1'b1;
                tx_last  = (b == nb - 1);
                if (b == nb - 1 && r != 0)
                    tx_keep = 8'((1 << r) - 1) | (8'($urandom) & (8'hFF << (r + 1)));
                else if (b == nb - 1)
                    tx_keep = 8'hFF;
                else
                    tx_keep = 8'($urandom);
                guard = 0;
                do begin
                    rstep();
                    guard++;
                end while (!fired && guard < 20);
                if (!fired) chk("rnd_accept_timeout", 0, 1);
            end
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat (8) rstep();
        chk("rnd_drain", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in = 1'b1;
        tx_data  = '0;
        tx_keep  = 8'h00;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        u_data   = 64'h8877665544332211;
        u_keep   = 8'h00;

        tv[0]  = '{8'hFF, 64'h8877665544332211, 8'h00};
        tv[1]  = '{8'h00, 64'h07070707070707FD, 8'hFF};
        tv[2]  = '{8'h01, 64'h070707070707FD11, 8'hFE};
        tv[3]  = '{8'h03, 64'h0707070707FD2211, 8'hFC};
        tv[4]  = '{8'h07, 64'h07070707FD332211, 8'hF8};
        tv[5]  = '{8'h0F, 64'h070707FD44332211, 8'hF0};
        tv[6]  = '{8'h1F, 64'h0707FD5544332211, 8'hE0};
        tv[7]  = '{8'h3F, 64'h07FD665544332211, 8'hC0};
        tv[8]  = '{8'h7F, 64'hFD77665544332211, 8'h80};
        tv[9]  = '{8'h0B, 64'h0707070707FD2211, 8'hFC};
        tv[10] = '{8'hF7, 64'h07070707FD332211, 8'hF8};
        tv[11] = '{8'h80, 64'h07070707070707FD, 8'hFF};

        for (int i = 0; i < 12; i++) begin
            u_keep = tv[i].keep;
            #1;
            checks++;
            if (u_txd !== tv[i].txd || u_txc !== tv[i].txc) begin
                failures++;
                $display("FAIL term_tbl keep=%h: got txd=%h txc=%h expected txd=%h txc=%h",
                         tv[i].keep, u_txd, u_txc, tv[i].txd, tv[i].txc);
            end
        end

        // reset
        for (int i = 0; i < 3; i++) begin
            expw("reset_idle", IW, 8'hFF, 1'b0, 1'b0);
            chk("reset_ready", int'(tx_ready), 0);
        end
        reset_in = 1'b0;
        expw("post_reset_idle", IW, 8'hFF, 1'b0, 1'b0);
        expw("post_reset_idle", IW, 8'hFF, 1'b0, 1'b0);

        // 16-byte frame
        tx_valid = 1'b1; tx_data = D0; tx_last = 1'b0; tx_keep = 8'hFF;
        expw("f16_pre", XGMII_PREAMBLE, 8'h01, 1'b0, 1'b0);
        chk("f16_ready", int'(tx_ready), 1);
        expw("f16_d0", D0, 8'h00, 1'b0, 1'b0);
        tx_data = D1; tx_last = 1'b1;
        expw("f16_d1", D1, 8'h00, 1'b0, 1'b0);
        tx_valid = 1'b0; tx_last = 1'b0;
        expw("f16_term", TW, 8'hFF, 1'b1, 1'b0);
        chk("f16_ifg_ready", int'(tx_ready), 0);
        expw("f16_ifg0", IW, 8'hFF, 1'b0, 1'b0);
        expw("f16_ifg1", IW, 8'hFF, 1'b0, 1'b0);

        // 13-byte frame
        tx_valid = 1'b1; tx_data = D0; tx_last = 1'b0;
        expw("f13_pre", XGMII_PREAMBLE, 8'h01, 1'b0, 1'b0);
        expw("f13_d0", D0, 8'h00, 1'b0, 1'b0);
        tx_data = D1; tx_last = 1'b1; tx_keep = 8'h1F;
        expw("f13_term", 64'h0707FDBBCCDDEEFF, 8'hE0, 1'b1, 1'b0);
        tx_valid = 1'b0; tx_last = 1'b0; tx_keep = 8'hFF;
        expw("f13_ifg0", IW, 8'hFF, 1'b0, 1'b0);
        expw("f13_ifg1", IW, 8'hFF, 1'b0, 1'b0);
        expw("f13_idle", IW, 8'hFF, 1'b0, 1'b0);

        // underrun then drain
        tx_valid = 1'b1; tx_data = D0; tx_last = 1'b0;
        expw("ur_pre", XGMII_PREAMBLE, 8'h01, 1'b0, 1'b0);
        expw("ur_d0", D0, 8'h00, 1'b0, 1'b0);
        tx_valid = 1'b0;
        expw("ur_err", ERRW, 8'hFF, 1'b0, 1'b1);
        chk("ur_drain_ready", int'(tx_ready), 1);
        tx_valid = 1'b1; tx_data = D1;
        expw("ur_drain0", IW, 8'hFF, 1'b0, 1'b0);
        expw("ur_drain1", IW, 8'hFF, 1'b0, 1'b0);
        tx_last = 1'b1;
        expw("ur_drain2", IW, 8'hFF, 1'b0, 1'b0);
        chk("ur_ifg_ready", int'(tx_ready), 0);
        tx_valid = 1'b0; tx_last = 1'b0;
        expw("ur_ifg0", IW, 8'hFF, 1'b0, 1'b0);
        chk("ur_ifg0_ready", int'(tx_ready), 0);
        expw("ur_ifg1", IW, 8'hFF, 1'b0, 1'b0);

        // back-to-back, valid held high
        tx_valid = 1'b1; tx_data = D0; tx_last = 1'b1; tx_keep = 8'hFF;
        expw("b2b_pre_a", XGMII_PREAMBLE, 8'h01, 1'b0, 1'b0);
        expw("b2b_d0", D0, 8'h00, 1'b0, 1'b0);
        tx_data = D2; tx_keep = 8'h0F;
        expw("b2b_term_a", TW, 8'hFF, 1'b1, 1'b0);
        chk("b2b_ifg_ready0", int'(tx_ready), 0);
        expw("b2b_ifg0", IW, 8'hFF, 1'b0, 1'b0);
        chk("b2b_ifg_ready1", int'(tx_ready), 0);
        expw("b2b_ifg1", IW, 8'hFF, 1'b0, 1'b0);
        chk("b2b_idle_ready", int'(tx_ready), 0);
        expw("b2b_pre_b", XGMII_PREAMBLE, 8'h01, 1'b0, 1'b0);
        expw("b2b_term_b", 64'h070707FDCAFEF00D, 8'hF0, 1'b1, 1'b0);
        tx_valid = 1'b0; tx_last = 1'b0; tx_keep = 8'hFF;
        expw("b2b_ifg2", IW, 8'hFF, 1'b0, 1'b0);
        expw("b2b_ifg3", IW, 8'hFF, 1'b0, 1'b0);

        // reset mid-frame
        tx_valid = 1'b1; tx_data = D0; tx_last = 1'b0;
        expw("mr_pre", XGMII_PREAMBLE, 8'h01, 1'b0, 1'b0);
        expw("mr_d0", D0, 8'h00, 1'b0, 1'b0);
        tx_data = D1;
        reset_in = 1'b1;
        expw("mr_reset0", IW, 8'hFF, 1'b0, 1'b0);
        expw("mr_reset1", IW, 8'hFF, 1'b0, 1'b0);
        chk("mr_ready", int'(tx_ready), 0);
        reset_in = 1'b0; tx_valid = 1'b0;
        expw("mr_idle", IW, 8'hFF, 1'b0, 1'b0);
        tx_valid = 1'b1; tx_data = D2; tx_last = 1'b1; tx_keep = 8'hFF;
        expw("mr_pre2", XGMII_PREAMBLE, 8'h01, 1'b0, 1'b0);
        expw("mr_d2", D2, 8'h00, 1'b0, 1'b0);
        tx_valid = 1'b0; tx_last = 1'b0;
        expw("mr_term", TW, 8'hFF, 1'b1, 1'b0);
        expw("mr_ifg0", IW, 8'hFF, 1'b0, 1'b0);
        expw("mr_ifg1", IW, 8'hFF, 1'b0, 1'b0);

        // randomized frames against the byte-level model
        reset_in = 1'b1;
        step();
        step();
        reset_in = 1'b0;
        step();
        seen_t   = 1'b0;
        idle_run = 0;
        run_random(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
